// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I funct3 codes for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - access-size codes (funct3[1:0]) and byte-lane mask constants
//   - FSM state enum (IDLE, WRITE, RESP)
//   - helpers: funct3 legality, misalignment detection, offset alignment,
//     lane-mask generation and store-lane merging
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Byte-lane masks for an access starting at lane 0.
    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_RESP  = 2'b10
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the low offset bits that a halfword or word access may not use.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        logic [1:0] a;
        case (f3[1:0])
            SIZE_H:  a = {off[1], 1'b0};
            SIZE_W:  a = 2'b00;
            default: a = off;
        endcase
        return a;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            SIZE_B:  m = LANE_B << off;
            SIZE_H:  m = LANE_H << {off[1], 1'b0};
            SIZE_W:  m = LANE_W;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replace the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] repl;
        logic [31:0] merged;
        logic [3:0]  m;
        case (f3[1:0])
            SIZE_B:  repl = {4{wdata[7:0]}};
            SIZE_H:  repl = {2{wdata[15:0]}};
            default: repl = wdata;
        endcase
        m = lane_mask(f3, off);
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = m[i] ? repl[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Request/response handshake and data-memory port of the load/store unit.
//   slave  : the LSU side (accepts requests, drives responses and memory port)
//   master : the requester + memory side
// Parameter ADDR_W: word-index width of the data memory.
// -----------------------------------------------------------------------------
interface lsu_if #(parameter int ADDR_W = 5);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic              mem_sw;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_data, mem_sw
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_data, mem_sw
    );
endinterface

// File: rtl/lsu_extend.sv
// -----------------------------------------------------------------------------
// lsu_extend
// Combinational load-data formatter: selects the addressed byte (off_i) or
// halfword (off_i[1]) of word_i and sign- or zero-extends it per funct3_i.
// Ports: word_i (raw memory word), funct3_i (load code), off_i (byte offset),
//        data_o (extended result; 0 for non-load codes).
// -----------------------------------------------------------------------------
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by sign/zero extension.
    always_comb begin
        byte_s = word_i[{off_i, 3'b000} +: 8];
        half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data_o = {{16{half_s[15]}}, half_s};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'h000000, byte_s};
            F3_LHU:  data_o = {16'h0000, half_s};
            default: data_o = 32'h00000000;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit in front of a 32-bit word memory with a
// combinational read port and a clocked write port.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : lsu_if.slave -- req_* handshake, resp_* pulse, mem_* port
// Loads answer one cycle after accept (IDLE->RESP); stores do a
// read-merge-write (IDLE->WRITE->RESP). Illegal funct3 answers with resp_err.
// Optional feature macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses are answered with resp_err; otherwise the offending
// low address bits are cleared and the access proceeds.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
)(
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);
    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wr_word_q, wr_word_d;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept_s;
    logic [ADDR_W-1:0] req_idx_s;
    logic              legal_s;
    logic              trap_s;
    logic [1:0]        eff_off_s;
    logic [31:0]       load_data_s;

    assign req_idx_s = bus.req_addr[ADDR_W+1:2];
    assign legal_s   = f3_legal(bus.req_we, bus.req_funct3);
    assign accept_s  = bus.req_valid & (state_q == ST_IDLE) & rst_n;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s    = misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign eff_off_s = bus.req_addr[1:0];
`else
    assign trap_s    = 1'b0;
    assign eff_off_s = align_off(bus.req_funct3, bus.req_addr[1:0]);
`endif

    lsu_extend u_extend (
        .word_i   (bus.mem_rd_data),
        .funct3_i (bus.req_funct3),
        .off_i    (eff_off_s),
        .data_o   (load_data_s)
    );

    // Next-state, request latching and response formation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        off_d     = off_q;
        wr_word_d = wr_word_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    idx_d    = req_idx_s;
                    funct3_d = bus.req_funct3;
                    we_d     = bus.req_we;
                    off_d    = eff_off_s;
                    if (!legal_s || trap_s) begin
                        result_d = 32'h00000000;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else if (bus.req_we) begin
                        wr_word_d = merge_store(bus.mem_rd_data, bus.req_wdata,
                                                bus.req_funct3, eff_off_s);
                        result_d  = 32'h00000000;
                        err_d     = 1'b0;
                        state_d   = ST_WRITE;
                    end else begin
                        result_d = load_data_s;
                        err_d    = 1'b0;
                        state_d  = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Response registers are loaded on the edge that enters RESP so they
        // are valid for exactly that cycle.
        if (state_d == ST_RESP) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = result_d;
            resp_err_d   = err_d;
        end else begin
            resp_valid_d = 1'b0;
            resp_rdata_d = 32'h00000000;
            resp_err_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            funct3_q     <= 3'b000;
            we_q         <= 1'b0;
            off_q        <= 2'b00;
            wr_word_q    <= 32'h00000000;
            result_q     <= 32'h00000000;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h00000000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            off_q        <= off_d;
            wr_word_q    <= wr_word_d;
            result_q     <= result_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE) & rst_n;
    assign bus.mem_rd_addr = (state_q == ST_IDLE) ? req_idx_s : idx_q;
    assign bus.mem_wr_addr = idx_q;
    assign bus.mem_wr_data = wr_word_q;
    // Beyond the WRITE state, the latched request must still describe a legal
    // store so a corrupted latch can never commit a write; rst_n aborts the
    // write in the same cycle.
    assign bus.mem_sw      = (state_q == ST_WRITE) & rst_n & we_q
                             & f3_legal(1'b1, funct3_q)
                             & (lane_mask(funct3_q, off_q) != 4'b0000);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 5: word-index width of the attached data memory (32 words).
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  execute stage presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 req_addr  input  ADDR_W+2  byte address.
REQ-009 req_wdata  input  32  store data; low byte/half used for SB/SH.
REQ-010 resp_valid  output  1  one-cycle response pulse.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal funct3 or trapped misalignment.
REQ-013 mem_rd_addr  output  ADDR_W  word index to memory's combinational read port.
REQ-014 mem_rd_data  input  32  memory read data, same cycle.
REQ-015 mem_wr_addr  output  ADDR_W  word index for write.
REQ-016 mem_wr_data  output  32  full merged write word.
REQ-017 mem_sw  output  1  memory write enable, sampled by memory on rising clk.

Function
REQ-018 FSM states IDLE, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 In IDLE, mem_rd_addr = req_addr[ADDR_W+1:2]; otherwise it holds the latched request's index.
REQ-020 Accept = req_valid & req_ready; on accept, latch index, funct3, we, byte offset, and compute result from mem_rd_data that cycle.
REQ-021 Load accept: IDLE->RESP; resp_valid=1 for exactly the RESP cycle; RESP->IDLE unconditionally (load latency 1, throughput 1 per 2 cycles).
REQ-022 Load extension: LB/LH sign-extend, LBU/LHU zero-extend selected byte (addr[1:0]) or half (addr[1]); LW passes word.
REQ-023 Store accept: merged word = mem_rd_data with lane(s) replaced (SB lane addr[1:0], SH lanes addr[1]); IDLE->WRITE.
REQ-024 WRITE: mem_sw=1 for exactly one cycle with latched index and merged word; WRITE->RESP; RESP->IDLE (store throughput 1 per 3 cycles).
REQ-025 A load accepted the cycle after a store's RESP reads the updated word.
REQ-026 Illegal funct3 (load 011/110/111; store 011-111): no write, go to RESP with resp_err=1, resp_rdata=0.
REQ-027 No response backpressure; req_valid while busy is ignored and must be held by the requester.
REQ-028 mem_sw=0 in every state other than WRITE.

Reset
REQ-029 rst_n low at a rising edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched fields=0.
REQ-030 mem_sw gated by rst_n; a reset during WRITE aborts the write, no partial store committed.
REQ-031 No request accepted in a cycle where rst_n is low.

Configuration
REQ-032 LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 gives no write, RESP with resp_err=1, resp_rdata=0.
REQ-033 LSU_MISALIGN_TRAP_EN undefined: offending low address bits forced to 0 (aligned down), access proceeds normally, resp_err reflects only illegal funct3.

Structure
REQ-034 Package lsu_pkg holds funct3 constants (LB..SW), FSM state enum, byte-lane select helper constants.
REQ-035 One sub-module lsu_extend: combinational byte/half select plus sign/zero extension for loads.

Verification
REQ-036 Reset, then SW addr 0x08 data 0xDEADBEEF -> mem_sw one cycle at index 2 with 0xDEADBEEF; resp_valid next cycle, resp_err=0.
REQ-037 Word 2 = 0xDEADBEEF; LB addr 0x0B -> resp_rdata 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x08 -> 0xFFFFBEEF.
REQ-038 Word 2 = 0xDEADBEEF; SB addr 0x09 data 0x12 -> memory 0xDEAD12EF; SH addr 0x0A data 0x5678 -> 0x567812EF.
REQ-039 LH addr 0x05 -> trap build: resp_err=1, rdata 0; non-trap build: reads half at 0x04.
REQ-040 Store funct3 111 -> mem_sw never asserted, resp_err=1; rst_n low during WRITE -> mem_sw 0, word unchanged, IDLE next.
